// File: rtl/path_sequencer.sv
// path_sequencer
// Node-by-node path controller. A planner loads an ordered list of
// {node id, turn code} entries; each accepted node_changed pulse during a
// run advances the list, updating the upcoming turn and the last traversed
// node, until the list is exhausted.
//
// Ports:
//   clk_3125KHz   system clock (rising edge)
//   reset         asynchronous active-high reset
//   load_start    pulse: begin loading a new path
//   wr_valid      path entry valid; wr_data = {node id[6:2], turn[1:0]}
//   wr_last       final entry qualifier
//   wr_ready      high while loading (decoded from state only)
//   run           pulse: start traversal
//   abort         level: return to IDLE, clear everything
//   node_changed  pulse: line follower left a node
//   turn_flag     turn code for the upcoming node
//   realtime_pos  id of the most recently traversed node
//   end_path      path complete, held in DONE
//   busy          traversal in progress
//   path_len      entries loaded
//   node_idx      entries consumed
//   truncated     sticky: buffer filled without wr_last
module path_sequencer #(
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned GUARD_CYCLES = 3125,
    parameter logic [4:0]  START_POS    = 5'd0
) (
    input  logic                         clk_3125KHz,
    input  logic                         reset,
    input  logic                         load_start,
    input  logic                         wr_valid,
    input  logic [6:0]                   wr_data,
    input  logic                         wr_last,
    output logic                         wr_ready,
    input  logic                         run,
    input  logic                         abort,
    input  logic                         node_changed,
    output logic [1:0]                   turn_flag,
    output logic [4:0]                   realtime_pos,
    output logic                         end_path,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   path_len,
    output logic [$clog2(DEPTH+1)-1:0]   node_idx,
    output logic                         truncated
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, ARMED, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [6:0]      mem [DEPTH];
    logic [GW-1:0]   guard;
    logic [CW-1:0]   len_inc, idx_inc;
    logic            len_full, last_node, accept, restart, wr_en;

    assign len_inc   = path_len + CW'(1);
    assign idx_inc   = node_idx + CW'(1);
    assign len_full  = (len_inc == CW'(DEPTH));
    assign last_node = (idx_inc == path_len);
    assign accept    = (state == RUN) && node_changed && (guard == '0);
    // load_start is honoured everywhere except RUN
    assign restart   = load_start && (state != RUN);
    assign wr_en     = (state == LOAD) && wr_valid && !load_start && !abort;

    // State register
    always_ff @(posedge clk_3125KHz or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else if (restart) begin
            state_next = LOAD;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                LOAD:    if (wr_valid && (wr_last || len_full)) state_next = ARMED;
                ARMED:   if (run) state_next = RUN;
                RUN:     if (accept && last_node) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs decoded straight from the state register
    always_comb begin
        wr_ready = (state == LOAD);
        busy     = (state == RUN);
    end

    // Path storage; contents need no reset
    always_ff @(posedge clk_3125KHz) begin
        if (wr_en) mem[path_len[AW-1:0]] <= wr_data;
    end

    // Registered datapath
    always_ff @(posedge clk_3125KHz or posedge reset) begin
        if (reset) begin
            turn_flag    <= '0;
            realtime_pos <= START_POS;
            end_path     <= 1'b0;
            path_len     <= '0;
            node_idx     <= '0;
            truncated    <= 1'b0;
            guard        <= '0;
        end else if (abort) begin
            turn_flag    <= '0;
            realtime_pos <= START_POS;
            end_path     <= 1'b0;
            path_len     <= '0;
            node_idx     <= '0;
            truncated    <= 1'b0;
            guard        <= '0;
        end else if (restart) begin
            turn_flag    <= '0;
            end_path     <= 1'b0;
            path_len     <= '0;
            node_idx     <= '0;
            truncated    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (wr_valid) begin
                        path_len <= len_inc;
                        if (wr_last || len_full) begin
                            // Entry 0 may be written on this same edge
                            turn_flag <= (path_len == '0) ? wr_data[1:0]
                                                          : mem[0][1:0];
                        end
                        if (!wr_last && len_full) truncated <= 1'b1;
                    end
                end
                ARMED: begin
                    if (run) begin
                        realtime_pos <= START_POS;
                        guard        <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        realtime_pos <= mem[node_idx[AW-1:0]][6:2];
                        node_idx     <= idx_inc;
                        guard        <= GW'(GUARD_CYCLES);
                        if (last_node) begin
                            end_path  <= 1'b1;
                            turn_flag <= '0;
                        end else begin
                            turn_flag <= mem[idx_inc[AW-1:0]][1:0];
                        end
                    end else if (guard != '0) begin
                        guard <= guard - GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/path_sequencer.md
# path_sequencer

Node-by-node path controller for the line-following datapath. A path planner loads an ordered list of node entries (node id plus turn code). During the run, each `node_changed` pulse from the line follower advances the list. The block drives `turn_flag` for the next node, `realtime_pos` for the last traversed node, and `end_path` once the list is exhausted. It sits between the path planner and the line-follower motor controller, running on the same 3.125 MHz clock.

## Interface
- `DEPTH`, 32: maximum path entries (power of two, ≥2).
- `GUARD_CYCLES`, 3125: node-event lockout after an accepted event (1 ms at 3.125 MHz), ≥1.
- `START_POS`, 5'd0: node id reported before the first node is traversed.
- `clk_3125KHz` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `load_start` in 1: 1-cycle pulse, begin loading a new path.
- `wr_valid` in 1: path entry valid.
- `wr_data` in 7: `[6:2]` node id, `[1:0]` turn code (0 straight, 1 right, 2 U-turn, 3 left).
- `wr_last` in 1: qualifies `wr_data` as the final entry.
- `wr_ready` out 1: entry accepted when `wr_valid && wr_ready`.
- `run` in 1: 1-cycle pulse, start traversal (driven from the start key).
- `abort` in 1: level, force return to IDLE.
- `node_changed` in 1: 1-cycle pulse from line follower on leaving a node.
- `turn_flag` out 2: turn code for the upcoming node.
- `realtime_pos` out 5: id of the most recently traversed node.
- `end_path` out 1: path complete, held until leaving DONE.
- `busy` out 1: high in RUN.
- `path_len` out clog2(DEPTH+1): entries loaded.
- `node_idx` out clog2(DEPTH+1): entries consumed.
- `truncated` out 1: sticky, buffer filled without `wr_last`.

## Operation
- Storage: DEPTH×7 register array, write pointer and read pointer. The read pointer is `node_idx`.
- States: IDLE, LOAD, ARMED, RUN, DONE.
- IDLE: `load_start` → LOAD; clears `path_len`, `node_idx`, `truncated`, `end_path`.
- LOAD: `wr_ready`=1. Each accepted entry is written at `path_len`, then `path_len`++.
  - Accepted entry with `wr_last`=1 → ARMED.
  - Accepted entry that makes `path_len`==DEPTH with `wr_last`=0 → ARMED, and `truncated`←1.
  - `run` is ignored in LOAD.
- ARMED: `turn_flag` = turn code of entry 0. `run` → RUN with `realtime_pos`←START_POS and guard counter 0. `load_start` → LOAD (reload, clears as in IDLE).
- RUN: a node event is accepted when `node_changed`=1 and the guard counter is 0. On acceptance:
  - `realtime_pos`←node id of entry[`node_idx`].
  - `node_idx`++.
  - Guard counter←GUARD_CYCLES.
  - If `node_idx`+1==`path_len` → DONE. Otherwise `turn_flag`←turn code of entry[`node_idx`+1].
- RUN, guard handling: the guard counter decrements to 0 and saturates. `node_changed` while the guard counter is nonzero is dropped with no state change. `load_start` and `run` are ignored in RUN.
- DONE: `end_path`=1, `turn_flag`=0. `load_start` → LOAD, which deasserts `end_path`. `run` is ignored.
- `node_changed` outside RUN: ignored.
- `abort` (any state, highest priority) → IDLE next edge. Clears `turn_flag`, `end_path`, `node_idx`, `path_len`, guard counter; `realtime_pos`←START_POS; `truncated` cleared. Array contents are don't-care.
- Simultaneous `wr_valid` and `load_start` in LOAD: `load_start` wins. Pointers clear and the entry is not written.

## Timing
- All outputs registered except `wr_ready`, which decodes state (LOAD) only, with no combinational path from `wr_valid`.
- Reset values: state IDLE, `turn_flag` 0, `realtime_pos` START_POS, `end_path` 0, `busy` 0, `path_len` 0, `node_idx` 0, `truncated` 0, guard counter 0.
- Write latency: `path_len` updates on the edge that samples the handshake.
- `wr_ready` drops the cycle after the last accepted entry.
- ARMED `turn_flag`: valid the cycle after entering ARMED.
- Node latency: `realtime_pos`, `turn_flag`, `node_idx` and `end_path` update on the edge that samples the accepted `node_changed`, valid the following cycle.
- Guard window: after an event accepted at edge N, a `node_changed` at edges N+1 … N+GUARD_CYCLES is dropped. The first acceptable edge is N+GUARD_CYCLES+1.
- `busy` = (state==RUN).
- Asserting `reset` mid-RUN clears outputs immediately, independent of the clock.

## Test plan
- Load 3 entries {pos 5 turn 1, pos 9 turn 3, pos 12 turn 0, last}, then `run`:
  - After load: `path_len`=3, `turn_flag`=1.
  - Event 1 → `realtime_pos`=5, `turn_flag`=3.
  - Event 2 → `realtime_pos`=9, `turn_flag`=0.
  - Event 3 → `realtime_pos`=12, `end_path`=1, `busy`=0.
- Guard window with GUARD_CYCLES=4: pulses at cycles 0, 2 and 5 → events accepted at 0 and 5 only; `node_idx` goes 1 then 2.
- DEPTH=4, load 5 entries with no `wr_last`:
  - 4 entries accepted, `wr_ready`=0 from the 5th, `truncated`=1, `path_len`=4.
  - 4 events → `end_path`=1.
- `abort` after the 2nd of 3 events → next cycle IDLE, `realtime_pos`=0, `node_idx`=0, `turn_flag`=0. A later `node_changed` is ignored.
- Async `reset` pulse between clock edges during RUN → outputs at reset values before the next edge, and `end_path` never asserts.
- Stray input pulses:
  - `node_changed` in IDLE/ARMED → no change.
  - `run` during LOAD → ignored; state reaches ARMED on `wr_last`.
  - `load_start` in DONE → `end_path`=0, `path_len`=0, `wr_ready`=1.
